// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and mode constants for the serial arithmetic engine.
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first, with start/busy/done handshake.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sub,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic carry, mode_q, cs, cc;
  logic [WIDTH-1:0] nsum;
  // subtraction is a + ~b + 1: invert b per bit, seed the carry with 1
  fa_cell u_fa (.a(a), .b(b ^ mode_q), .cin(carry), .s(cs), .co(cc));
  assign nsum = {cs, sum[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      mode_q <= MODE_ADD;
      sum    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            mode_q <= sub ? MODE_SUB : MODE_ADD;
            carry  <= (sub == MODE_SUB);
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
            zero   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= cc;
          sum   <= nsum;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= cc;
            ovf   <= carry ^ cc;
            neg   <= cs ^ carry ^ cc;
            zero  <= (nsum == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of 8-, 2- and 32-bit serial adder/subtractor instances.
module tb_serial_addsub;
  logic clk = 1'b0, rstn = 1'b1, a = 1'b0, b = 1'b0, sub = 1'b0;
  logic [2:0] st = '0;
  logic [7:0] s8;
  logic [1:0] s2;
  logic [31:0] s32;
  logic [2:0] bz, dn, co, ov, ng, zr;
  int errors = 0, checks = 0, cyc = 0, last = 0;

  serial_addsub #(.WIDTH(8)) u8 (.clk(clk), .rstn(rstn), .start(st[0]), .sub(sub), .a(a), .b(b),
    .sum(s8), .busy(bz[0]), .done(dn[0]), .cout(co[0]), .ovf(ov[0]), .neg(ng[0]), .zero(zr[0]));
  serial_addsub #(.WIDTH(2)) u2 (.clk(clk), .rstn(rstn), .start(st[1]), .sub(sub), .a(a), .b(b),
    .sum(s2), .busy(bz[1]), .done(dn[1]), .cout(co[1]), .ovf(ov[1]), .neg(ng[1]), .zero(zr[1]));
  serial_addsub #(.WIDTH(32)) u32 (.clk(clk), .rstn(rstn), .start(st[2]), .sub(sub), .a(a), .b(b),
    .sum(s32), .busy(bz[2]), .done(dn[2]), .cout(co[2]), .ovf(ov[2]), .neg(ng[2]), .zero(zr[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res(input int k);
    return k == 0 ? 32'(s8) : k == 1 ? 32'(s2) : s32;
  endfunction

  task automatic op(input int k, input int w, input logic s, input logic [31:0] x, input logic [31:0] y);
    int c0;
    @(negedge clk);
    st[k] = 1'b1;
    sub = s;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      st[k] = 1'b0;
      a = x[i];
      b = y[i];
      if (i == 1) begin
        check("busy_run", 32'(bz[k]), 1);
        check("done_run", 32'(dn[k]), 0);
        check("flags_run", {co[k], ov[k], ng[k], zr[k]}, 0);
      end
    end
    @(negedge clk);
    check("done", 32'(dn[k]), 1);
    check("busy_done", 32'(bz[k]), 0);
    check("latency", 32'(cyc - c0), 32'(w));
  endtask

  task automatic res_chk(input string tag, input int k, input logic [31:0] es, input logic [3:0] ef);
    check({tag, "_sum"}, res(k), es);
    check({tag, "_flags"}, {co[k], ov[k], ng[k], zr[k]}, 32'(ef));
  endtask

  initial begin
    logic [7:0] xa[3] = '{8'hFF, 8'h05, 8'h5A};
    logic [7:0] xb[3] = '{8'h01, 8'h07, 8'h33};
    logic       xs[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] es[3] = '{8'h00, 8'hFE, 8'h8D};
    logic seen;
    #2 rstn = 1'b0;
    #1;
    check("rst_sum8", 32'(s8), 0);
    check("rst_sum32", s32, 0);
    check("rst_ctl", {bz, dn}, 0);
    check("rst_flags", {co, ov, ng, zr}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // flags ordered {cout, ovf, neg, zero}
    op(0, 8, 1'b0, 32'h5A, 32'h33); res_chk("add_5a_33", 0, 32'h8D, 4'b0100);
    op(0, 8, 1'b1, 32'h05, 32'h07); res_chk("sub_05_07", 0, 32'hFE, 4'b0010);
    op(0, 8, 1'b1, 32'h10, 32'h10); res_chk("sub_10_10", 0, 32'h00, 4'b1001);
    op(0, 8, 1'b1, 32'h80, 32'h01); res_chk("sub_80_01", 0, 32'h7F, 4'b1110);
    op(0, 8, 1'b0, 32'hFF, 32'h01); res_chk("add_ff_01", 0, 32'h00, 4'b1001);

    // back-to-back with start held, start/sub noise during RUN
    @(negedge clk);
    st[0] = 1'b1;
    sub = xs[0];
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        a = xa[k][i];
        b = xb[k][i];
        st[0] = i[0];
        sub = ~xs[k];
        check("b2b_busy", 32'(bz[0]), 1);
      end
      @(negedge clk);
      check("b2b_done", 32'(dn[0]), 1);
      check("b2b_busy_done", 32'(bz[0]), 0);
      check("b2b_sum", 32'(s8), 32'(es[k]));
      if (k > 0) check("b2b_period", 32'(cyc - last), 9);
      last = cyc;
      sub = xs[k < 2 ? k + 1 : 0];
      st[0] = (k < 2);
    end
    @(negedge clk);
    check("b2b_pulse", 32'(dn[0]), 0);
    check("b2b_idle_busy", 32'(bz[0]), 0);
    check("b2b_hold", 32'(s8), 32'h8D);
    check("b2b_hold_flags", {co[0], ov[0], ng[0], zr[0]}, 32'b0100);

    // reset during bit 3
    @(negedge clk);
    st[0] = 1'b1;
    sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st[0] = 1'b0;
      a = 1'b1;
      b = 1'b0;
    end
    @(negedge clk);
    check("mid_busy", 32'(bz[0]), 1);
    check("mid_partial", 32'(s8), 32'hE0);
    rstn = 1'b0;
    #1;
    check("mid_rst_sum", 32'(s8), 0);
    check("mid_rst_ctl", {bz[0], dn[0]}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= dn[0];
    end
    check("mid_no_done", 32'(seen), 0);
    op(0, 8, 1'b0, 32'h01, 32'h01); res_chk("after_rst", 0, 32'h02, 4'b0000);

    op(1, 2, 1'b1, 32'h1, 32'h2); res_chk("w2_sub", 1, 32'h3, 4'b0100);
    op(2, 32, 1'b0, 32'hFFFF_FFFF, 32'h1); res_chk("w32_add", 2, 32'h0, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
